// File: rtl/ibex_rf_wport_arbiter.sv
// Register-file write-port arbiter: LSU load responses normally win, EX is boosted after
// StarveLimit blocked cycles and a colliding load is parked in a one-entry hold buffer.
// Optional conflict counter enabled by defining IBEX_RF_ARB_PERF_EN.
module ibex_rf_wport_arbiter #(
    parameter int unsigned StarveLimit = 3,
    parameter int unsigned AddrWidth   = 5,
    parameter int unsigned DataWidth   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [AddrWidth-1:0] ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,

    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic                 lsu_err_i,
    input  logic [AddrWidth-1:0] lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,

    output logic                 rf_we_o,
    output logic [AddrWidth-1:0] rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,

    output logic                 hold_valid_o,
    output logic [AddrWidth-1:0] hold_waddr_o,
    output logic [DataWidth-1:0] hold_wdata_o,

    output logic [15:0]          perf_conflict_cnt_o
);

    // Handshakes: a transfer happens in a cycle where valid and ready are both high;
    // valid must not depend on ready, ready may depend on valid (ex_ready_o does).
    localparam logic [3:0] StarveMax = 4'(StarveLimit);

    logic                 hold_valid_q, hold_valid_d;
    logic                 hold_err_q, hold_err_d;
    logic [AddrWidth-1:0] hold_waddr_q, hold_waddr_d;
    logic [DataWidth-1:0] hold_wdata_q, hold_wdata_d;
    logic [3:0]           starve_q, starve_d;
    logic                 rf_we_q, rf_we_d;
    logic [AddrWidth-1:0] rf_waddr_q, rf_waddr_d;
    logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;

    logic                 lsu_acc;
    logic                 boost;
    logic                 grant_h, grant_l, grant_e;
    logic                 capture;
    logic                 wr_valid;
    logic                 wr_err;
    logic [AddrWidth-1:0] wr_addr;
    logic [DataWidth-1:0] wr_data;

    assign lsu_ready_o = !hold_valid_q;
    assign lsu_acc     = lsu_valid_i & !hold_valid_q;
    assign boost       = ex_valid_i & (starve_q == StarveMax);

    assign grant_h = !boost & hold_valid_q;
    assign grant_l = !boost & lsu_acc;
    assign grant_e = ex_valid_i & (boost | (!hold_valid_q & !lsu_acc));
    // A load arriving while EX is boosted is parked instead of dropped.
    assign capture = boost & lsu_acc;

    assign ex_ready_o = grant_e;

    always_comb begin
        wr_valid = 1'b0;
        wr_err   = 1'b0;
        wr_addr  = rf_waddr_q;
        wr_data  = rf_wdata_q;
        if (grant_h) begin
            wr_valid = 1'b1;
            wr_err   = hold_err_q;
            wr_addr  = hold_waddr_q;
            wr_data  = hold_wdata_q;
        end else if (grant_l) begin
            wr_valid = 1'b1;
            wr_err   = lsu_err_i;
            wr_addr  = lsu_waddr_i;
            wr_data  = lsu_wdata_i;
        end else if (grant_e) begin
            wr_valid = 1'b1;
            wr_addr  = ex_waddr_i;
            wr_data  = ex_wdata_i;
        end
    end

    // x0 and faulted loads still consume the grant but never reach the register file.
    assign rf_we_d    = wr_valid & (wr_addr != '0) & !wr_err;
    assign rf_waddr_d = wr_addr;
    assign rf_wdata_d = wr_data;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_err_d   = hold_err_q;
        hold_waddr_d = hold_waddr_q;
        hold_wdata_d = hold_wdata_q;
        if (grant_h) begin
            hold_valid_d = 1'b0;
        end else if (capture) begin
            hold_valid_d = 1'b1;
            hold_err_d   = lsu_err_i;
            hold_waddr_d = lsu_waddr_i;
            hold_wdata_d = lsu_wdata_i;
        end
    end

    always_comb begin
        starve_d = 4'd0;
        if (ex_valid_i && !grant_e) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_valid_q <= 1'b0;
            hold_err_q   <= 1'b0;
            hold_waddr_q <= '0;
            hold_wdata_q <= '0;
            starve_q     <= 4'd0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_err_q   <= hold_err_d;
            hold_waddr_q <= hold_waddr_d;
            hold_wdata_q <= hold_wdata_d;
            starve_q     <= starve_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;
    assign hold_valid_o = hold_valid_q;
    assign hold_waddr_o = hold_waddr_q;
    assign hold_wdata_o = hold_wdata_q;

`ifdef IBEX_RF_ARB_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (ex_valid_i && !ex_ready_o && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_q <= 16'h0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_conflict_cnt_o = perf_q;
`else
    assign perf_conflict_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_ibex_rf_wport_arbiter.sv
// Directed bench for ibex_rf_wport_arbiter: grants, starvation boost, hold buffer,
// write suppression, reset while holding, and the optional conflict counter.
module tb_ibex_rf_wport_arbiter;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        lsu_valid;
  logic        lsu_ready;
  logic        lsu_err;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        hold_valid;
  logic [4:0]  hold_waddr;
  logic [31:0] hold_wdata;
  logic [15:0] perf_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_perf;

  ibex_rf_wport_arbiter #(
    .StarveLimit(3),
    .AddrWidth(5),
    .DataWidth(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .ex_valid_i(ex_valid),
    .ex_ready_o(ex_ready),
    .ex_waddr_i(ex_waddr),
    .ex_wdata_i(ex_wdata),
    .lsu_valid_i(lsu_valid),
    .lsu_ready_o(lsu_ready),
    .lsu_err_i(lsu_err),
    .lsu_waddr_i(lsu_waddr),
    .lsu_wdata_i(lsu_wdata),
    .rf_we_o(rf_we),
    .rf_waddr_o(rf_waddr),
    .rf_wdata_o(rf_wdata),
    .hold_valid_o(hold_valid),
    .hold_waddr_o(hold_waddr),
    .hold_wdata_o(hold_wdata),
    .perf_conflict_cnt_o(perf_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_ex(input logic v, input logic [4:0] a, input logic [31:0] d);
    ex_valid = v;
    ex_waddr = a;
    ex_wdata = d;
  endtask

  task automatic drive_lsu(input logic v, input logic e, input logic [4:0] a, input logic [31:0] d);
    lsu_valid = v;
    lsu_err   = e;
    lsu_waddr = a;
    lsu_wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(we), 32'(rf_we));
    chk({tag, "_we"}, 32'(rf_we), 32'(we));
    chk({tag, "_addr"}, 32'(rf_waddr), 32'(a));
    chk({tag, "_data"}, rf_wdata, d);
  endtask

  initial begin
    rst = 1'b1;
    exp_perf = 16'd0;
    drive_ex(1'b0, 5'd0, 32'h0);
    drive_lsu(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_hold", 32'(hold_valid), 32'd0);
    chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("rst_ex_ready", 32'(ex_ready), 32'd0);
    chk("rst_perf", 32'(perf_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // EX alone
    drive_ex(1'b1, 5'd5, 32'h1234);
    #1;
    chk("ex_only_ready", 32'(ex_ready), 32'd1);
    tick();
    expect_write("ex_only", 1'b1, 5'd5, 32'h1234);

    // LSU and EX collide: LSU first, EX next
    drive_ex(1'b1, 5'd3, 32'h33);
    drive_lsu(1'b1, 1'b0, 5'd7, 32'hAA);
    #1;
    chk("coll_ex_ready", 32'(ex_ready), 32'd0);
    chk("coll_lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    exp_perf = exp_perf + 16'd1;
    expect_write("coll_lsu", 1'b1, 5'd7, 32'hAA);
    drive_lsu(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("coll_ex_ready2", 32'(ex_ready), 32'd1);
    tick();
    expect_write("coll_ex", 1'b1, 5'd3, 32'h33);
    drive_ex(1'b0, 5'd0, 32'h0);
    tick();
    chk("idle_we", 32'(rf_we), 32'd0);

    // starvation: three blocked cycles, then a boost cycle
    drive_ex(1'b1, 5'd4, 32'h44);
    for (int i = 1; i <= 3; i++) begin
      drive_lsu(1'b1, 1'b0, 5'(10 + i), 32'h1000 + 32'(i));
      #1;
      chk("starve_ex_ready", 32'(ex_ready), 32'd0);
      tick();
      exp_perf = exp_perf + 16'd1;
      expect_write("starve_lsu", 1'b1, 5'(10 + i), 32'h1000 + 32'(i));
    end
    drive_lsu(1'b1, 1'b0, 5'd14, 32'h1004);
    #1;
    chk("boost_ex_ready", 32'(ex_ready), 32'd1);
    chk("boost_lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    expect_write("boost_ex", 1'b1, 5'd4, 32'h44);
    chk("boost_hold_valid", 32'(hold_valid), 32'd1);
    chk("boost_hold_addr", 32'(hold_waddr), 32'd14);
    chk("boost_hold_data", hold_wdata, 32'h1004);
    chk("hold_lsu_ready", 32'(lsu_ready), 32'd0);

    // drain: new LSU response waits one cycle
    drive_ex(1'b0, 5'd0, 32'h0);
    drive_lsu(1'b1, 1'b0, 5'd15, 32'h1005);
    #1;
    chk("drain_lsu_ready", 32'(lsu_ready), 32'd0);
    tick();
    expect_write("drain_hold", 1'b1, 5'd14, 32'h1004);
    chk("drain_hold_valid", 32'(hold_valid), 32'd0);
    chk("after_drain_lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    expect_write("after_drain_lsu", 1'b1, 5'd15, 32'h1005);

    // write suppression
    drive_lsu(1'b1, 1'b1, 5'd9, 32'hDEAD);
    tick();
    expect_write("lsu_err", 1'b0, 5'd9, 32'hDEAD);
    drive_lsu(1'b0, 1'b0, 5'd0, 32'h0);
    drive_ex(1'b1, 5'd0, 32'h77);
    #1;
    chk("x0_ex_ready", 32'(ex_ready), 32'd1);
    tick();
    expect_write("ex_x0", 1'b0, 5'd0, 32'h77);

    // one more blocked cycle so the conflict count reaches 5
    drive_ex(1'b1, 5'd6, 32'h66);
    drive_lsu(1'b1, 1'b0, 5'd8, 32'h88);
    tick();
    exp_perf = exp_perf + 16'd1;
    drive_lsu(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    expect_write("ex_after_block", 1'b1, 5'd6, 32'h66);
`ifdef IBEX_RF_ARB_PERF_EN
    chk("perf_count", 32'(perf_cnt), 32'(exp_perf));
`else
    chk("perf_count", 32'(perf_cnt), 32'd0);
`endif

    // fill the hold buffer again, then reset while it is occupied
    drive_ex(1'b1, 5'd2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      drive_lsu(1'b1, 1'b0, 5'd20, 32'hBEEF);
      tick();
    end
    chk("pre_rst_hold_valid", 32'(hold_valid), 32'd1);
    rst = 1'b1;
    drive_ex(1'b0, 5'd0, 32'h0);
    drive_lsu(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("mid_rst_hold_valid", 32'(hold_valid), 32'd0);
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    chk("mid_rst_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("mid_rst_perf", 32'(perf_cnt), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_we", 32'(rf_we), 32'd0);
      chk("post_rst_hold_valid", 32'(hold_valid), 32'd0);
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ibex_rf_wport_arbiter.md
Name: ibex_rf_wport_arbiter

Overview:
- Shares the single register-file write port between two writers:
  - EX/WB results: ALU/multiplier writes, valid/ready handshake.
  - LSU load responses: valid/ready with a one-entry hold buffer.
- Sits between the writeback stage outputs and the register file write port.
- Fixed LSU priority, with an anti-starvation boost for EX.
- Exports hold-buffer status so ID can stall on, or forward from, a parked load.

Parameters:
- StarveLimit, 3, consecutive EX-blocked cycles before EX is boosted (1..15).
- AddrWidth, 5, register address width.
- DataWidth, 32, register data width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- ex_valid_i  in  1  EX write request
- ex_ready_o  out  1  EX request granted this cycle
- ex_waddr_i  in  AddrWidth  EX destination register
- ex_wdata_i  in  DataWidth  EX write data
- lsu_valid_i  in  1  LSU load response valid
- lsu_ready_o  out  1  LSU response accepted (hold buffer empty)
- lsu_err_i  in  1  LSU response error; suppresses the write
- lsu_waddr_i  in  AddrWidth  load destination register
- lsu_wdata_i  in  DataWidth  load data
- rf_we_o  out  1  register-file write enable (registered)
- rf_waddr_o  out  AddrWidth  register-file write address (registered)
- rf_wdata_o  out  DataWidth  register-file write data (registered)
- hold_valid_o  out  1  hold buffer occupied
- hold_waddr_o  out  AddrWidth  hold buffer destination register
- hold_wdata_o  out  DataWidth  hold buffer data, for forwarding
- perf_conflict_cnt_o  out  16  EX-blocked cycle count (optional feature)

Behaviour:
- Reset (rst_i=1, asynchronous): all registered outputs, hold buffer, starve_cnt and the perf counter go to 0.
- Combinational outputs during reset:
  - lsu_ready_o=1.
  - ex_ready_o follows the arbitration equations (reset state: hold empty, not boosted).
- Reset mid-operation discards any held load and any pending grant; nothing is written after reset asserts.
- lsu_ready_o = !hold_valid. An LSU response is accepted when lsu_valid_i & lsu_ready_o.
- boost = ex_valid_i & (starve_cnt == StarveLimit).
- Grant rules, evaluated each cycle, exactly one winner:
  - Normal mode (!boost), priority order:
    - If hold_valid: grant H (hold buffer); hold empties next cycle.
    - Else if an LSU response is accepted: grant L.
    - Else grant E if ex_valid_i.
  - Boost mode:
    - Grant E.
    - If an LSU response is accepted in the same cycle (hold empty), capture it into the hold buffer (valid, addr, data, err).
    - If hold is full, H waits.
- ex_ready_o = 1 only when E is granted; it is combinational and may depend on lsu_valid_i.
- Write port, 1-cycle latency:
  - The granted entry's addr/data register into rf_waddr_o/rf_wdata_o on the next edge.
  - rf_we_o=1 unless the granted addr==0 or the granted LSU/held entry has err=1; in those cases rf_we_o=0 and addr/data still update.
  - rf_we_o=0 in any cycle with no grant.
- Starve counter:
  - Increments, saturating at StarveLimit, when ex_valid_i & !ex_ready_o.
  - Clears to 0 on an EX handshake or when !ex_valid_i.
- Hold buffer behaviour:
  - Filled only in boost mode; drained with top priority the next non-boost cycle.
  - Back-to-back boosts cannot occur: the counter clears on the EX grant.
  - A held entry with err=1 drains with no write.
- Ordering: the same-register ordering between a held load and a later EX write is ID's responsibility, using hold_valid_o/hold_waddr_o to stall or forward.
- Simultaneous hold drain and a new LSU response: the new response is not accepted (lsu_ready_o=0) until the cycle after the drain.

Optional Feature:
- Macro: IBEX_RF_ARB_PERF_EN.
- With the macro:
  - 16-bit counter increments every cycle with ex_valid_i & !ex_ready_o.
  - Saturates at 16'hFFFF; reset to 0.
  - Drives perf_conflict_cnt_o.
- Without the macro: the counter logic is absent and perf_conflict_cnt_o is tied to 16'h0.

Test Plan:
- EX only, ex_valid_i=1, waddr=5, wdata=0x1234:
  - ex_ready_o=1 in the same cycle.
  - Next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234.
- LSU and EX together for one cycle (lsu addr 7/data 0xAA, ex addr 3):
  - LSU written first, EX stalled.
  - EX written the following cycle; starve_cnt returns to 0.
- LSU valid continuously, EX valid, StarveLimit=3:
  - EX blocked 3 cycles; 4th cycle is boost: EX granted, LSU response captured, hold_valid_o=1.
  - Next cycle hold drains; lsu_ready_o=0 during the hold-full cycle.
- Write suppression:
  - LSU response with lsu_err_i=1, addr 9 -> rf_we_o=0.
  - EX write to addr 0 -> rf_we_o=0, ex_ready_o=1.
- rst_i asserted while hold_valid=1 -> hold_valid_o=0 and rf_we_o=0 immediately; no write of the held data after release.
- Optional feature, macro defined: 5 EX-blocked cycles -> perf_conflict_cnt_o=5. Macro undefined -> reads 0.
